// File: rtl/instr_fetch_queue.sv
// Fetch stage: one outstanding imem read, results buffered in a small FIFO.
// Define IFQ_FAULT_CHECK_EN to turn bad fetch addresses into faulting NOPs.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter logic [31:0] IMEM_LAST = 32'h0100_07FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef IFQ_FAULT_CHECK_EN
  ,
  output logic        instr_fault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_data [DEPTH];

  logic        accept;
  logic        bad_pc;
  logic        push;
  logic        pop;
  logic [31:0] push_pc;
  logic [31:0] push_data;

  // Ready only when a free slot exists, so every accept owns a slot.
  assign pc_ready = !rst && state == IDLE
                 && count < FULL && !flush;
  assign accept   = pc_valid && pc_ready;

`ifdef IFQ_FAULT_CHECK_EN
  assign bad_pc = pc_addr[1:0] != 2'b00
               || pc_addr < IMEM_BASE
               || pc_addr > IMEM_LAST;
`else
  assign bad_pc = 1'b0;
`endif

  assign push = !flush
             && ((state == WAIT && imem_ack)
             ||  (accept && bad_pc));
  assign pop  = instr_valid && instr_ready && !flush;

  assign push_pc   = (state == WAIT) ? imem_addr : pc_addr;
  assign push_data = (state == WAIT) ? imem_rdata : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= IMEM_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !bad_pc) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc_addr;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= push_pc;
      q_data[wr_ptr] <= push_data;
    end
  end

  assign instr_valid = count != '0;
  assign instr_pc    = q_pc[rd_ptr];
  assign instr_data  = q_data[rd_ptr];

`ifdef IFQ_FAULT_CHECK_EN
  logic q_flt [DEPTH];

  always_ff @(posedge clk) begin
    if (push) q_flt[wr_ptr] <= (state != WAIT);
  end

  assign instr_fault = q_flt[rd_ptr];
`endif

endmodule
